// File: rtl/mc_pkg.sv
// Shared encodings for the multiply/divide unit and the core control FSM.
package mc_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef logic [1:0] md_state_t;

  localparam md_state_t MD_IDLE = 2'd0;
  localparam md_state_t MD_RUN  = 2'd1;
  localparam md_state_t MD_FIN  = 2'd2;

endpackage

// File: rtl/mc_muldiv_step.sv
// One iteration of the iterative datapath: right shift-add for multiply,
// left restoring shift-subtract for divide, on a 2*WIDTH accumulator.
module mc_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Shifted partial remainder needs WIDTH+1 bits; diff[WIDTH] is the borrow.
    diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    acc_next = {sum, acc[WIDTH-1:1]};
    if (div) begin
      if (!diff[WIDTH]) begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mc_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one step per bit.
// Handshake: start is accepted only while idle; busy covers RUN and FIN; done pulses one cycle with hi/lo valid.
module mc_muldiv
  import mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output md_state_t        dbg_state
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          st;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [1:0]         op_q;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               b_zero;
  logic               done_q;

  assign is_div    = (op_q == MD_DIVU) || (op_q == MD_DIV);
  assign busy      = (st != MD_IDLE);
  assign done      = done_q;
  assign dbg_state = st;

  always_comb begin
    a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    b_mag = (op[0] && b[WIDTH-1]) ? -b : b;
    quo   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    prod  = neg_res ? -acc : acc;
  end

  mc_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div      (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= MD_IDLE;
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      a_raw   <= '0;
      op_q    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      done_q  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done_q <= 1'b0;
      case (st)
        MD_IDLE: begin
          if (start) begin
            op_q    <= op;
            neg_res <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= op[0] & a[WIDTH-1];
            b_zero  <= (b == '0);
            a_raw   <= a;
            cnt     <= CW'(WIDTH - 1);
            // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
            if (op[1]) begin
              acc     <= {{WIDTH{1'b0}}, a_mag};
              operand <= b_mag;
            end else begin
              acc     <= {{WIDTH{1'b0}}, b_mag};
              operand <= a_mag;
            end
            st <= MD_RUN;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MD_RUN: begin
          acc <= acc_next;
          if (cnt == '0) begin
            st <= MD_FIN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MD_FIN: begin
          if (is_div && b_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          done_q <= 1'b1;
          st     <= MD_IDLE;
        end
        default: st <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_muldiv.sv
// Bench for mc_muldiv (WIDTH=32): cycle-level behavioural model plus directed literal checks.
module tb_mc_muldiv;
  import mc_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  md_state_t     dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  mc_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] ux;
    logic [63:0] uy;
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    ux = {32'b0, x};
    uy = {32'b0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MD_MULTU: return ux * uy;
      MD_MULT:  return 64'(sx * sy);
      MD_DIVU: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Behavioural model: remaining cycles of the operation in flight, results queued at accept.
  logic [63:0]  exp_q[$];
  int           m_rem = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always @(posedge clk) begin
    logic [63:0] r;
    m_done = 1'b0;
    if (rst) begin
      m_rem = 0;
      m_hi  = '0;
      m_lo  = '0;
      exp_q.delete();
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && exp_q.size() > 0) begin
        r      = exp_q.pop_front();
        m_hi   = r[63:32];
        m_lo   = r[31:0];
        m_done = 1'b1;
      end
    end else if (start) begin
      exp_q.push_back(ref_result(op, a, b));
      m_rem = W + 1;
    end else begin
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
    end
  end

  // scoreboard compare on the opposite edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
      check("busy_done_excl", 64'(busy & done), 64'd0);
    end
  end

  // driver tasks (called at #1 after a rising edge)
  task automatic wait_done(output int lat, inout int busy_cyc);
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [63:0] exp_lit);
    int lat;
    int bc;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom_range(0, 3));
    bc    = busy ? 1 : 0;
    wait_done(lat, bc);
    check({name, "_latency"}, 64'(lat), 64'd33);
    check({name, "_busy_cycles"}, 64'(bc), 64'd33);
    check({name, "_result"}, {hi, lo}, exp_lit);
  endtask

  initial begin
    int lat;
    int bc;
    int n_done;
    logic [1:0] ro;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    chk_en = 1'b1;

    // pin the model to hand-computed values
    check("pin_multu", ref_result(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    check("pin_mult", ref_result(MD_MULT, 32'hFFFF_FFFD, 32'h5), 64'hFFFF_FFFF_FFFF_FFF1);
    check("pin_div_ovf", ref_result(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("pin_div_neg", ref_result(MD_DIV, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);

    // directed: consecutive calls also exercise start in the done cycle
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg3x5", MD_MULT, 32'hFFFF_FFFD, 32'h5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("mult_7xm1", MD_MULT, 32'h7, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9);
    run_op("divu_7_2", MD_DIVU, 32'h7, 32'h2, 64'h0000_0001_0000_0003);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("divu_by0", MD_DIVU, 32'h0000_1234, 32'h0, 64'h0000_1234_FFFF_FFFF);
    run_op("div_by0", MD_DIV, 32'h8000_0001, 32'h0, 64'h8000_0001_FFFF_FFFF);

    // start and hi_we pulsed mid-RUN must not disturb the operation
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; op = MD_MULTU; a = 32'd1000; b = 32'd3000;
    @(posedge clk);
    #1;
    start = 1'b0;
    bc = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      bc++;
    end
    start = 1'b1; op = MD_DIV; a = 32'hFFFF_0000; b = 32'h7;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bc++;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    wait_done(lat, bc);
    check("midrun_latency", 64'(lat), 64'd27);
    check("midrun_result", {hi, lo}, 64'h0000_0000_002D_C6C0);

    // MTHI/MTLO in idle
    @(posedge clk);
    #1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi", 64'(hi), 64'hDEAD_BEEF);
    check("mtlo", 64'(lo), 64'hDEAD_BEEF);

    // reset ten cycles into a MULTU
    start = 1'b1; op = MD_MULTU; a = 32'h1234; b = 32'h5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    n_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("rst_mid_no_done", 64'(n_done), 64'd0);

    // randomized operations with idle MTHI/MTLO traffic and in-flight noise
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        wdata = $urandom;
        @(posedge clk);
        #1;
      end
      hi_we = 1'b0; lo_we = 1'b0;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 7) == 0) ry = '0;
      if ($urandom_range(0, 15) == 0) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 20));
      start = 1'b1; op = ro; a = rx; b = ry;
      @(posedge clk);
      #1;
      lat = 0;
      while (!done && lat < 50) begin
        start = 1'($urandom_range(0, 1));
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
        wdata = $urandom;
        @(posedge clk);
        #1;
        lat++;
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      check("rand_latency", 64'(lat), 64'd33);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
